// File: rtl/parity_frame_tx.sv
// Serial frame transmitter with a parity bit.
//
// A frame is START (0), DATA_WIDTH data bits LSB first, one parity bit and
// STOP (1). Each bit is held for CLKS_PER_BIT clock cycles. The line idles
// high and is driven straight from a flop.
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   rstn      synchronous active-low reset
//   tx_data   word to send; sampled only when tx_valid && tx_ready
//   tx_valid  tx_data holds a word to send
//   tx_ready  high in IDLE once out of reset; a word can be accepted this cycle
//   tx_out    serial line
//   busy      a frame is in progress
//   tx_done   high during the last cycle of STOP

module parity_frame_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned ODD_PARITY   = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    // Both counters need at least one bit, even when the count is 1.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic             PAR_INV  = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    tx_out_q, tx_out_d;
    // Holds tx_ready low in the cycle following a reset edge.
    logic                    ready_en_q;

    logic bit_end;
    logic accept;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign tx_ready = ready_en_q && (state_q == StIdle);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != StIdle);
    assign tx_out   = tx_out_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_done  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ PAR_INV;
                    idx_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = StParity;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        // The line level is registered, so derive it from the state being entered.
        case (state_d)
            StStart:  tx_out_d = 1'b0;
            StData:   tx_out_d = shift_d[0];
            StParity: tx_out_d = parity_d;
            default:  tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

    localparam int DW        = 8;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = (DW + 3) * CPB;

    logic clk;
    logic rstn;

    // Main instance: 8 data bits, 4 clocks per bit, even parity.
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_out, busy, tx_done;

    // 4 data bits, 1 clock per bit, even parity.
    logic [3:0] s1_data;
    logic       s1_valid, s1_ready, s1_out, s1_busy, s1_done;

    // 8 data bits, 1 clock per bit, odd parity.
    logic [7:0] s2_data;
    logic       s2_valid, s2_ready, s2_out, s2_busy, s2_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    parity_frame_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
        .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
    );

    parity_frame_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1), .ODD_PARITY(0)) dut_s1 (
        .clk(clk), .rstn(rstn), .tx_data(s1_data), .tx_valid(s1_valid),
        .tx_ready(s1_ready), .tx_out(s1_out), .busy(s1_busy), .tx_done(s1_done)
    );

    parity_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .ODD_PARITY(1)) dut_s2 (
        .clk(clk), .rstn(rstn), .tx_data(s2_data), .tx_valid(s2_valid),
        .tx_ready(s2_ready), .tx_out(s2_out), .busy(s2_busy), .tx_done(s2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Line level c cycles after the frame starts, from the frame format alone.
    function automatic logic model_bit(input logic [15:0] w, input int dw, input int cpb,
                                       input int odd, input int c);
        int slot;
        slot = c / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= dw) return w[slot-1];
        if (slot == dw + 1) return ((($countones(w) + odd) % 2) != 0);
        return 1'b1;
    endfunction

    // Offer a word; returns at posedge+1 after it is accepted (or the bound runs out).
    task automatic send(input logic [7:0] w, input bit keep);
        logic acc;
        acc = 1'b0;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = (tx_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        check("accept_within_bound", acc, 1'b1);
        if (acc) exp_q.push_back(w);
        if (!keep) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            idle = (busy === 1'b0);
        end
        check("idle_within_bound", idle, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each falling edge of the idle line starts a frame, compared
    // cycle by cycle against the oldest queued word.
    initial begin : monitor
        logic [7:0] w;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx_out === 1'b0) begin
                check("frame_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() == 0) begin
                    repeat (FRAME_CYC) @(negedge clk);
                end else begin
                    w = exp_q.pop_front();
                    aborted = 1'b0;
                    for (int c = 0; c < FRAME_CYC; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rstn !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("frame_tx_out", tx_out, model_bit({8'h00, w}, DW, CPB, 0, c));
                        check("frame_busy", busy, 1'b1);
                        check("frame_tx_done", tx_done, (c == FRAME_CYC - 1));
                        check("frame_tx_ready", tx_ready, 1'b0);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (rstn === 1'b1) begin
                            check("gap_tx_out", tx_out, 1'b1);
                            check("gap_busy", busy, 1'b0);
                            check("gap_tx_ready", tx_ready, 1'b1);
                            check("gap_tx_done", tx_done, 1'b0);
                        end
                    end
                end
            end
        end
    end

    task automatic small_tests();
        logic       seq1[7];
        logic [7:0] w2[2];
        logic       par2[2];
        seq1 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        w2   = '{8'h01, 8'h00};
        par2 = '{1'b0, 1'b1};

        s1_data  = 4'b1011;
        s1_valid = 1'b1;
        @(negedge clk);
        check("s1_ready", s1_ready, 1'b1);
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("s1_tx_out", s1_out, seq1[c]);
            check("s1_tx_done", s1_done, (c == 6));
        end
        @(negedge clk);
        check("s1_idle_after", s1_busy, 1'b0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            s2_data  = w2[k];
            s2_valid = 1'b1;
            @(negedge clk);
            check("s2_ready", s2_ready, 1'b1);
            @(posedge clk);
            #1;
            s2_valid = 1'b0;
            for (int c = 0; c < 11; c++) begin
                @(negedge clk);
                if (c == 9) check("s2_parity", s2_out, par2[k]);
                else check("s2_tx_out", s2_out, model_bit({8'h00, w2[k]}, 8, 1, 1, c));
                check("s2_tx_done", s2_done, (c == 10));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stimulus
        logic [7:0] w;
        int         gap;
        rstn     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s1_valid = 1'b0;
        s1_data  = 4'h0;
        s2_valid = 1'b0;
        s2_data  = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single frames.
        send(8'hA5, 1'b0);
        wait_idle();
        send(8'h01, 1'b0);
        wait_idle();

        // tx_valid held high across two words.
        send(8'h3C, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();

        // Data change and a valid pulse mid-frame must not disturb anything.
        send(8'h55, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        // Reset during data bit 3 (cycles 17..20 after accept).
        send(8'h96, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_tx_out", tx_out, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_tx_done", tx_done, 1'b0);
        check("abort_tx_ready", tx_ready, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_abort", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        send(8'hC3, 1'b0);
        wait_idle();

        // Random words, sometimes back-to-back.
        for (int i = 0; i < 20; i++) begin
            w   = 8'($urandom);
            gap = $urandom_range(0, 3);
            send(w, (gap == 0));
            if (gap != 0) begin
                wait_idle();
                repeat (gap - 1) @(posedge clk);
                #1;
            end
        end
        tx_valid = 1'b0;
        wait_idle();

        small_tests();

        repeat (FRAME_CYC + 5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
